// File: rtl/uart_tx.sv
// UART transmitter: 8N1 framing with a small transmit FIFO and a sticky overflow flag.
// Bit timing comes from CLK_FREQ / BOUD_RATE whole clocks per bit.
module uart_tx #(
  parameter int CLK_FREQ   = 27_000_000,
  parameter int BOUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       tx_pin,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  output logic       full,
  output logic       busy,
  output logic       overflow,
  input  logic       clear_overflow
);

  localparam int CYCLE = CLK_FREQ / BOUD_RATE;
  localparam int CW    = (CYCLE > 1) ? $clog2(CYCLE) : 1;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CYCLE - 1);
  localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic            ovf_q;
  logic            push, pop, bit_end, fifo_nonempty;

  assign full          = (count_q == DEPTH);
  assign fifo_nonempty = (count_q != '0);
  assign busy          = (state_q != IDLE) || fifo_nonempty;
  assign push          = wr_en && !full;
  assign bit_end       = (cnt_q == CYC_LAST);
  assign tx_pin        = tx_q;
  assign overflow      = ovf_q;

  // Storage array carries no reset; only the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
      // A dropped write outranks a same-cycle clear.
      if (wr_en && full)       ovf_q <= 1'b1;
      else if (clear_overflow) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[bit_d];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // Chain straight into the next start bit when more data is waiting.
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a fast instance (10 clocks per bit) for framing, FIFO and
// reset behaviour, plus a default-clock instance at 9600 baud for exact bit timing.
module tb_uart_tx;

  localparam int C  = 10;    // 1000 Hz / 100 baud
  localparam int C2 = 2812;  // 27 MHz / 9600 baud

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx, full, busy, overflow;
  logic [7:0] wrData = '0;
  logic       wrEn = 1'b0;
  logic       clearOverflow = 1'b0;
  logic       tx2, full2, busy2, overflow2;
  logic [7:0] wrData2 = '0;
  logic       wrEn2 = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  uart_tx #(.CLK_FREQ(1000), .BOUD_RATE(100), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .tx_pin(tx), .wr_data(wrData), .wr_en(wrEn),
    .full(full), .busy(busy), .overflow(overflow), .clear_overflow(clearOverflow)
  );

  uart_tx #(.CLK_FREQ(27_000_000), .BOUD_RATE(9600), .FIFO_DEPTH(4)) dutSlow (
    .clk(clk), .rst(rst), .tx_pin(tx2), .wr_data(wrData2), .wr_en(wrEn2),
    .full(full2), .busy(busy2), .overflow(overflow2), .clear_overflow(1'b0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Advance n rising edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Behavioural line receiver: waits (bounded) for a start bit, then samples mid-bit.
  task automatic rxFrame(output logic [7:0] data, output logic frameOk,
                         output int startCyc, output logic timedOut);
    int waitN;
    waitN    = 0;
    data     = '0;
    frameOk  = 1'b0;
    startCyc = 0;
    timedOut = 1'b0;
    while (tx !== 1'b0 && waitN < 30 * C) begin
      tick(1);
      waitN++;
    end
    if (tx !== 1'b0) begin
      timedOut = 1'b1;
      return;
    end
    startCyc = cyc;
    tick(C / 2);
    frameOk = (tx === 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(C);
      data[i] = tx;
    end
    tick(C);
    frameOk = frameOk && (tx === 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(2);
    total++; if (tx !== 1'b1) begin bad++; $display("[TB] FAIL reset_tx: got %b expected 1", tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    total++; if (tx2 !== 1'b1 || busy2 !== 1'b0) begin bad++; $display("[TB] FAIL reset_slow: got tx=%b busy=%b expected tx=1 busy=0", tx2, busy2); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_single;
    logic [7:0] d; logic ok, to; int s, wrCyc;
    wrData = 8'h41; wrEn = 1'b1;
    tick(1);
    wrEn = 1'b0; wrCyc = cyc;
    total++; if (tx !== 1'b1) begin bad++; $display("[TB] FAIL single_latency_tx: got %b expected 1", tx); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL single_busy_queued: got %b expected 1", busy); end
    rxFrame(d, ok, s, to);
    total++; if (to !== 1'b0) begin bad++; $display("[TB] FAIL single_timeout: got %b expected 0", to); end
    total++; if (s !== wrCyc + 1) begin bad++; $display("[TB] FAIL single_start_edge: got %0d expected %0d", s, wrCyc + 1); end
    total++; if (d !== 8'h41) begin bad++; $display("[TB] FAIL single_data: got %h expected 41", d); end
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL single_framing: got %b expected 1", ok); end
    tick(C / 2 - 1);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL single_busy_last: got %b expected 1", busy); end
    tick(1);
    total++; if (busy !== 1'b0 || tx !== 1'b1) begin bad++; $display("[TB] FAIL single_busy_fall: got busy=%b tx=%b expected busy=0 tx=1", busy, tx); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d1, d2; logic ok1, ok2, to1, to2; int s1, s2;
    wrEn = 1'b1; wrData = 8'h55;
    tick(1);
    wrData = 8'hAA;
    tick(1);
    wrEn = 1'b0;
    rxFrame(d1, ok1, s1, to1);
    rxFrame(d2, ok2, s2, to2);
    total++; if (to1 !== 1'b0 || to2 !== 1'b0) begin bad++; $display("[TB] FAIL b2b_timeout: got %b%b expected 00", to1, to2); end
    total++; if (d1 !== 8'h55 || ok1 !== 1'b1) begin bad++; $display("[TB] FAIL b2b_first: got %h ok=%b expected 55 ok=1", d1, ok1); end
    total++; if (d2 !== 8'hAA || ok2 !== 1'b1) begin bad++; $display("[TB] FAIL b2b_second: got %h ok=%b expected aa ok=1", d2, ok2); end
    total++; if (s2 - s1 !== 10 * C) begin bad++; $display("[TB] FAIL b2b_spacing: got %0d expected %0d", s2 - s1, 10 * C); end
    tick(C / 2 - 1);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_busy_last: got %b expected 1", busy); end
    tick(1);
    total++; if (busy !== 1'b0 || cyc - s1 !== 20 * C) begin bad++; $display("[TB] FAIL b2b_total: got busy=%b len=%0d expected busy=0 len=%0d", busy, cyc - s1, 20 * C); end
  endtask

  task automatic test_overflow;
    logic [7:0] d; logic ok, to, sawLow; int s, sPrev, waitN;
    wrData = 8'hFF; wrEn = 1'b1;
    tick(1);
    wrEn = 1'b0;
    tick(1);
    sPrev = cyc;
    total++; if (tx !== 1'b0) begin bad++; $display("[TB] FAIL ovf_lead_start: got %b expected 0", tx); end
    for (int k = 1; k <= 5; k++) begin
      wrData = 8'(k); wrEn = 1'b1;
      tick(1);
      if (k == 3) begin
        total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL ovf_full_at3: got %b expected 0", full); end
      end
      if (k == 4) begin
        total++; if (full !== 1'b1 || overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_full_at4: got full=%b ovf=%b expected full=1 ovf=0", full, overflow); end
      end
      if (k == 5) begin
        total++; if (overflow !== 1'b1 || full !== 1'b1) begin bad++; $display("[TB] FAIL ovf_set: got ovf=%b full=%b expected ovf=1 full=1", overflow, full); end
      end
    end
    wrEn = 1'b0; clearOverflow = 1'b1;
    tick(1);
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_clear: got %b expected 0", overflow); end
    wrData = 8'h77; wrEn = 1'b1;
    tick(1);
    total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_set_wins: got %b expected 1", overflow); end
    wrEn = 1'b0;
    tick(1);
    clearOverflow = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_clear2: got %b expected 0", overflow); end
    waitN = 0;
    while (tx === 1'b0 && waitN < 2 * C) begin
      tick(1);
      waitN++;
    end
    for (int k = 1; k <= 4; k++) begin
      rxFrame(d, ok, s, to);
      total++; if (to !== 1'b0 || d !== 8'(k) || ok !== 1'b1) begin bad++; $display("[TB] FAIL ovf_frame%0d: got %h ok=%b to=%b expected %h ok=1 to=0", k, d, ok, to, 8'(k)); end
      total++; if (s - sPrev !== 10 * C) begin bad++; $display("[TB] FAIL ovf_spacing%0d: got %0d expected %0d", k, s - sPrev, 10 * C); end
      sPrev = s;
    end
    tick(C);
    sawLow = 1'b0;
    for (int i = 0; i < 3 * C; i++) begin
      tick(1);
      if (tx !== 1'b1) sawLow = 1'b1;
    end
    total++; if (sawLow !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL ovf_no_extra: got low=%b busy=%b expected low=0 busy=0", sawLow, busy); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d; logic ok, to, sawLow; int s, startCyc, wrCyc;
    wrEn = 1'b1;
    wrData = 8'h3C; tick(1);
    startCyc = cyc + 1;
    wrData = 8'h5A; tick(1);
    wrData = 8'h66; tick(1);
    wrEn = 1'b0;
    while (cyc < startCyc + 4 * C + C / 2) tick(1);
    total++; if (tx !== 1'b1 || busy !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_bit3: got tx=%b busy=%b expected tx=1 busy=1", tx, busy); end
    rst = 1'b1; wrEn = 1'b1; wrData = 8'h99;
    tick(1);
    total++; if (tx !== 1'b1 || busy !== 1'b0 || full !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_abort: got tx=%b busy=%b full=%b expected 1 0 0", tx, busy, full); end
    tick(1);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_wr_ignored: got %b expected 0", busy); end
    rst = 1'b0; wrEn = 1'b0;
    sawLow = 1'b0;
    for (int i = 0; i < 12 * C; i++) begin
      tick(1);
      if (tx !== 1'b1 || busy !== 1'b0) sawLow = 1'b1;
    end
    total++; if (sawLow !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_quiet: got activity=%b expected 0", sawLow); end
    wrData = 8'h0F; wrEn = 1'b1;
    tick(1);
    wrEn = 1'b0; wrCyc = cyc;
    rxFrame(d, ok, s, to);
    total++; if (to !== 1'b0 || s !== wrCyc + 1 || d !== 8'h0F || ok !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_resume: got %h ok=%b lat=%0d expected 0f ok=1 lat=1", d, ok, s - wrCyc); end
    tick(C);
  endtask

  task automatic test_loopback;
    logic [7:0] vals [2];
    logic [7:0] d; logic ok, to; int s;
    vals[0] = 8'h00; vals[1] = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      wrData = vals[i]; wrEn = 1'b1;
      tick(1);
      wrEn = 1'b0;
      rxFrame(d, ok, s, to);
      total++; if (to !== 1'b0 || d !== vals[i] || ok !== 1'b1) begin bad++; $display("[TB] FAIL loop_%0d: got %h ok=%b expected %h ok=1", i, d, ok, vals[i]); end
      tick(C);
    end
  endtask

  task automatic test_slow_baud;
    logic [9:0] fb;
    fb = {1'b1, 8'hA5, 1'b0};
    wrData2 = 8'hA5; wrEn2 = 1'b1;
    tick(1);
    wrEn2 = 1'b0;
    tick(1);
    for (int i = 0; i < 10; i++) begin
      total++; if (tx2 !== fb[i]) begin bad++; $display("[TB] FAIL slow_bit%0d_first: got %b expected %b", i, tx2, fb[i]); end
      tick(C2 - 1);
      total++; if (tx2 !== fb[i]) begin bad++; $display("[TB] FAIL slow_bit%0d_last: got %b expected %b", i, tx2, fb[i]); end
      if (i == 9) begin
        total++; if (busy2 !== 1'b1) begin bad++; $display("[TB] FAIL slow_busy_last: got %b expected 1", busy2); end
      end
      tick(1);
    end
    total++; if (busy2 !== 1'b0 || tx2 !== 1'b1) begin bad++; $display("[TB] FAIL slow_end: got busy=%b tx=%b expected 0 1", busy2, tx2); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_overflow;
    test_reset_mid;
    test_loopback;
    test_slow_baud;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 27_000_000, system clock frequency in Hz.
REQ-002 Parameter BOUD_RATE, default 115200, line bit rate in bit/s.
REQ-003 Parameter FIFO_DEPTH, default 4, transmit FIFO entries (power of two, >=2).
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 tx_pin  output  1  UART serial line, idle high, registered.
REQ-008 wr_data  input  8  byte to transmit.
REQ-009 wr_en  input  1  write strobe, one byte per cycle high.
REQ-010 full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-011 busy  output  1  frame in progress or FIFO non-empty.
REQ-012 overflow  output  1  sticky: write attempted while full.
REQ-013 clear_overflow  input  1  clears overflow.

Function
REQ-014 Bit period CYCLE = CLK_FREQ / BOUD_RATE (integer division; 234 at defaults); every bit lasts exactly CYCLE clocks.
REQ-015 Frame: start bit 0, 8 data bits LSB first, stop bit 1; frame length exactly 10*CYCLE clocks; no parity.
REQ-016 Write accepted at an edge where wr_en=1 and full=0; byte enters FIFO tail, count +1.
REQ-017 wr_en=1 while full=0 is accepted even if a pop occurs the same edge; wr_en=1 while full=1 is dropped (FIFO unchanged) and sets overflow at that edge, even if a pop occurs the same edge.
REQ-018 Simultaneous push and pop leave count unchanged; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-019 full and busy derive from registered state only (no combinational path from wr_en).
REQ-020 States: IDLE, START, DATA, STOP.
REQ-021 IDLE: tx_pin=1; if FIFO non-empty, pop head into shift register, tx_pin<=0, go START.
REQ-022 START: after CYCLE clocks, tx_pin<=bit0, bit index<=0, go DATA.
REQ-023 DATA: after each CYCLE clocks, shift to next bit; after bit7 period, tx_pin<=1, go STOP.
REQ-024 STOP: after CYCLE clocks, if FIFO non-empty pop and go START with tx_pin<=0 on the same edge (no idle gap), else go IDLE with tx_pin=1.
REQ-025 Latency: byte written at edge N into empty FIFO while IDLE -> tx_pin low after edge N+1.
REQ-026 Shift register is loaded only at pop; wr_data changes after acceptance do not affect frames.
REQ-027 busy=1 whenever state!=IDLE or FIFO count>0; busy=0 only in IDLE with empty FIFO.
REQ-028 clear_overflow=1 clears overflow at that edge; if a dropped write coincides, set wins (overflow=1).
REQ-029 Bit-period counter counts 0..CYCLE-1, width $clog2(CYCLE); it never exceeds CYCLE-1.

Reset
REQ-030 rst=1 at an edge: state IDLE, tx_pin=1, FIFO empty (pointers and count 0), full=0, busy=0, overflow=0, bit counters 0.
REQ-031 Reset mid-frame aborts the frame immediately: tx_pin=1 after that edge; FIFO contents discarded; wr_en ignored while rst=1.
REQ-032 After rst deasserts, the first accepted byte produces a full-length start bit per REQ-025.

Verification
REQ-033 Single byte: write 0x41 from idle -> tx_pin low one edge later; mid-bit samples 0,1,0,0,0,0,0,1,0,1; busy falls 10*CYCLE clocks after start edge.
REQ-034 Back-to-back: write 0x55 then 0xAA on consecutive cycles -> two frames, second start bit begins exactly 10*CYCLE clocks after first, total 20*CYCLE clocks, no idle cycle.
REQ-035 Overflow: with default FIFO_DEPTH=4 and a frame in progress, write 0x01..0x05 -> full=1 after fourth accepted write, 0x05 dropped, overflow=1; clear_overflow -> overflow=0 next cycle; 0x01..0x04 transmitted in order.
REQ-036 Reset mid-frame: rst=1 during DATA bit 3 with 2 bytes queued -> tx_pin=1, busy=0, full=0 after that edge; no further frames.
REQ-037 Loopback: tx_pin wired to uart_rx (same parameters), send 0x41 -> uart_rx available=1, data=0x41; repeat for 0x00 and 0xFF.
REQ-038 Non-default BOUD_RATE=9600: write 0xA5 -> each bit exactly 2812 clocks, frame 28120 clocks.
